complex_alu_seq: RTL and testbench

//  Issue controller for complex_alu. Accepts opcodes over a valid/ready handshake and drives
//  the 4-DSP config buses one cycle later. Tracks in-flight ops so results are not lost:

---
 rtl/complex_alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_complex_alu_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_alu_seq.sv
// Issue controller for complex_alu: registered opcode/cfg decode, in-flight tracking, credit-gated
// result FIFO. Define PERF_CNT_EN to add the perf_issue/perf_stall counters.
module complex_alu_seq #(
   parameter int ALU_LAT    = 7,
   parameter int FIFO_DEPTH = 8,
   parameter int TAG_W      = 4,
   parameter int ALUMODE_W  = 4,
   parameter int INMODE_W   = 5,
   parameter int OPMODE_W   = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             in_opcode,
   input  logic [TAG_W-1:0]       in_tag,
   output logic [2:0]             opcode,
   output logic [ALUMODE_W*4-1:0] alumode,
   output logic [INMODE_W*4-1:0]  inmode,
   output logic [OPMODE_W*4-1:0]  opmode,
   output logic [3:0]             cea2,
   output logic [3:0]             ceb2,
   output logic [3:0]             usemult,
   input  logic [31:0]            alu_dout,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [31:0]            res_data,
   output logic [TAG_W-1:0]       res_tag,
   output logic                   err_illegal
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]            perf_issue,
   output logic [31:0]            perf_stall
`endif
);

   localparam int NSTG  = ALU_LAT + 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [OPMODE_W-1:0]  OPM_MUL = OPMODE_W'(7'b0000101);
   localparam logic [OPMODE_W-1:0]  OPM_ACC = OPMODE_W'(7'b0110101);
   localparam logic [ALUMODE_W-1:0] ALM_ADD = '0;
   localparam logic [ALUMODE_W-1:0] ALM_SUB = ALUMODE_W'(4'b0011);

   logic                 out_of_reset;
   logic [CNT_W-1:0]     credit_cnt;
   logic                 accept;
   logic                 issue;
   logic                 op_illegal;
   logic                 pop;
   logic                 push;

   logic [OPMODE_W-1:0]  dec_opmode;
   logic [ALUMODE_W-1:0] dec_alumode;

   logic [TAG_W-1:0]     tag_q;
   logic [NSTG-1:0]      stg_vld;
   logic [TAG_W-1:0]     stg_tag [NSTG];

   logic [31:0]          fifo_data [FIFO_DEPTH];
   logic [TAG_W-1:0]     fifo_tag  [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     fifo_cnt;

   assign in_ready   = out_of_reset && (credit_cnt < CNT_W'(FIFO_DEPTH));
   assign accept     = in_valid && in_ready;
   assign issue      = accept && in_opcode[2];
   assign op_illegal = !in_opcode[2] && (in_opcode[1:0] != 2'b00);

   assign res_valid  = (fifo_cnt != '0);
   assign pop        = res_valid && res_ready;
   assign push       = stg_vld[NSTG-1];
   assign res_data   = fifo_data[rd_ptr];
   assign res_tag    = fifo_tag[rd_ptr];

   always_comb begin
      dec_opmode  = OPM_MUL;
      dec_alumode = ALM_ADD;
      case (in_opcode)
         3'b101: dec_opmode = OPM_ACC;
         3'b110: begin
            dec_opmode  = OPM_ACC;
            dec_alumode = ALM_SUB;
         end
         default: ;
      endcase
   end

   // in_ready stays low for the reset cycle and rises on the first edge after release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) out_of_reset <= 1'b0;
      else      out_of_reset <= 1'b1;
   end

   // NOP, illegal and idle cycles drive opcode 000 and leave the cfg buses untouched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opcode  <= 3'b000;
         alumode <= '0;
         inmode  <= '0;
         opmode  <= '0;
         cea2    <= 4'b0000;
         ceb2    <= 4'b0000;
         usemult <= 4'b0000;
         tag_q   <= '0;
      end else begin
         opcode <= issue ? in_opcode : 3'b000;
         if (issue) begin
            alumode <= {4{dec_alumode}};
            inmode  <= '0;
            opmode  <= {4{dec_opmode}};
            cea2    <= 4'b1111;
            ceb2    <= 4'b1111;
            usemult <= 4'b1111;
            tag_q   <= in_tag;
         end
      end
   end

   // Stage 0 follows the opcode register so the last stage lines up with alu_dout
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_vld <= '0;
         for (int i = 0; i < NSTG; i++) stg_tag[i] <= '0;
      end else begin
         stg_vld    <= {stg_vld[NSTG-2:0], opcode[2]};
         stg_tag[0] <= tag_q;
         for (int i = 1; i < NSTG; i++) stg_tag[i] <= stg_tag[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_tag[i]  <= '0;
         end
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= alu_dout;
            fifo_tag[wr_ptr]  <= stg_tag[NSTG-1];
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // One credit per non-NOP op, held from accept until its result is popped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_cnt <= '0;
      end else begin
         case ({issue, pop})
            2'b10:   credit_cnt <= credit_cnt + CNT_W'(1);
            2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         err_illegal <= 1'b0;
      else if (accept && op_illegal)    err_illegal <= 1'b1;
   end

`ifdef PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_issue <= '0;
         perf_stall <= '0;
      end else begin
         if (issue)                 perf_issue <= perf_issue + 32'd1;
         if (in_valid && !in_ready) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_complex_alu_seq.sv
// Directed bench for complex_alu_seq with a fixed-latency model of complex_alu.
module tb_complex_alu_seq;
   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        in_opcode = 3'b000;
   logic [TAG_W-1:0]  in_tag = '0;
   logic [2:0]        opcode;
   logic [15:0]       alumode;
   logic [19:0]       inmode;
   logic [27:0]       opmode;
   logic [3:0]        cea2, ceb2, usemult;
   logic [31:0]       alu_dout;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [31:0]       res_data;
   logic [TAG_W-1:0]  res_tag;
   logic              err_illegal;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   complex_alu_seq dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_tag(in_tag),
      .opcode(opcode), .alumode(alumode), .inmode(inmode), .opmode(opmode),
      .cea2(cea2), .ceb2(ceb2), .usemult(usemult), .alu_dout(alu_dout),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
      .err_illegal(err_illegal)
   );

   // complex_alu stand-in: result valid 8 edges after the opcode is seen, numbered per op
   logic [31:0] mpipe [8];
   logic [31:0] mcnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) mpipe[i] <= 32'h0;
         mcnt <= 32'h0;
      end else begin
         if (opcode != 3'b000) begin
            mpipe[0] <= 32'h1234ABCD + mcnt * 32'h00010001;
            mcnt     <= mcnt + 32'd1;
         end else begin
            mpipe[0] <= 32'hDEAD0000;
         end
         for (int i = 1; i < 8; i++) mpipe[i] <= mpipe[i-1];
      end
   end
   assign alu_dout = mpipe[7];

   function automatic logic [31:0] exp_data(input int m);
      return 32'h1234ABCD + 32'(m) * 32'h00010001;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int acc, got, res_idx;
      logic rdy, vld, iv, seen;
      logic [31:0] d;
      logic [TAG_W-1:0] t;
      logic [27:0] opm_mul, opm_acc;
      opm_mul = {4{7'b0000101}};
      opm_acc = {4{7'b0110101}};
      res_idx = 0;

      // 1: reset values
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_opcode", opcode, 0);
      chk("rst_cfg", {alumode, inmode, opmode, cea2, ceb2, usemult}, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_tag", res_tag, 0);
      chk("rst_err", err_illegal, 0);
      rst = 1'b1;
      #1;
      chk("rel_in_ready_low", in_ready, 0);
      tick();
      chk("rel_in_ready_high", in_ready, 1);

      // 2: single MUL, latency and decode
      in_valid = 1'b1; in_opcode = 3'b100; in_tag = 4'd3;
      tick();
      in_valid = 1'b0; in_opcode = 3'b000;
      chk("mul_opcode", opcode, 3'b100);
      chk("mul_opmode", opmode, opm_mul);
      chk("mul_alumode", alumode, 0);
      chk("mul_inmode", inmode, 0);
      chk("mul_ce", {cea2, ceb2, usemult}, 12'hFFF);
      tick();
      chk("idle_opcode", opcode, 0);
      chk("idle_opmode_held", opmode, opm_mul);
      repeat (7) tick();
      chk("mul_not_yet", res_valid, 0);
      tick();
      chk("mul_res_valid", res_valid, 1);
      chk("mul_res_data", res_data, 32'h1234ABCD);
      chk("mul_res_tag", res_tag, 3);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      res_idx++;
      chk("mul_popped", res_valid, 0);

      // 4: illegal opcode
      in_valid = 1'b1; in_opcode = 3'b010; in_tag = 4'd5;
      tick();
      in_valid = 1'b0; in_opcode = 3'b000;
      chk("ill_err", err_illegal, 1);
      chk("ill_opcode", opcode, 0);
      chk("ill_cfg_held", opmode, opm_mul);
      seen = 1'b0;
      repeat (12) begin
         tick();
         if (res_valid) seen = 1'b1;
      end
      chk("ill_no_result", seen, 0);

      // 3: 16 MULSUB with consumer stalled, then drained
      acc = 0;
      in_opcode = 3'b110;
      for (int c = 0; c < 30; c++) begin
         in_valid = 1'b1;
         in_tag = acc[3:0];
         rdy = in_ready;
         tick();
         if (rdy) acc++;
      end
      in_valid = 1'b0;
      chk("fill_accepted", acc, 8);
      chk("fill_in_ready", in_ready, 0);
      chk("mulsub_alumode", alumode, {4{4'b0011}});
      chk("mulsub_opmode", opmode, opm_acc);
      got = 0;
      for (int c = 0; c < 80 && got < 16; c++) begin
         iv = (acc < 16);
         in_valid = iv;
         in_tag = acc[3:0];
         res_ready = 1'b1;
         rdy = in_ready; vld = res_valid; d = res_data; t = res_tag;
         tick();
         if (iv && rdy) acc++;
         if (vld) begin
            chk("drain_tag", t, got[3:0]);
            chk("drain_data", d, exp_data(res_idx));
            got++;
            res_idx++;
         end
      end
      in_valid = 1'b0;
      chk("drain_count", got, 16);
      chk("drain_accepted", acc, 16);
      seen = 1'b0;
      repeat (12) begin
         tick();
         if (res_valid) seen = 1'b1;
      end
      chk("drain_no_dup", seen, 0);
      res_ready = 1'b0;

      // 5: MAX then MULADD adjacent
      in_valid = 1'b1; in_opcode = 3'b111; in_tag = 4'd1;
      tick();
      chk("max_opcode", opcode, 3'b111);
      chk("max_opmode", opmode, opm_mul);
      chk("max_alumode", alumode, 0);
      in_opcode = 3'b101; in_tag = 4'd2;
      tick();
      in_valid = 1'b0; in_opcode = 3'b000;
      chk("madd_opcode", opcode, 3'b101);
      chk("madd_opmode", opmode, opm_acc);
      chk("madd_alumode", alumode, 0);
      got = 0;
      for (int c = 0; c < 30 && got < 2; c++) begin
         res_ready = 1'b1;
         vld = res_valid; d = res_data; t = res_tag;
         tick();
         if (vld) begin
            chk("pair_tag", t, got + 1);
            chk("pair_data", d, exp_data(res_idx));
            got++;
            res_idx++;
         end
      end
      chk("pair_count", got, 2);
      res_ready = 1'b0;

      // 6: reset with ops in flight
      in_opcode = 3'b100;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_tag = 4'(i);
         tick();
      end
      in_valid = 1'b0; in_opcode = 3'b000;
      repeat (6) tick();
      chk("pre_rst_valid", res_valid, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_err", err_illegal, 0);
      chk("mid_rst_opcode", opcode, 0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      res_idx = 0;
      acc = 0;
      in_opcode = 3'b100;
      for (int c = 0; c < 14; c++) begin
         in_valid = 1'b1;
         in_tag = acc[3:0];
         rdy = in_ready;
         tick();
         if (rdy) acc++;
      end
      in_valid = 1'b0; in_opcode = 3'b000;
      chk("post_rst_credits", acc, 8);
      got = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         res_ready = 1'b1;
         vld = res_valid; d = res_data; t = res_tag;
         tick();
         if (vld) begin
            chk("post_rst_tag", t, got[3:0]);
            chk("post_rst_data", d, exp_data(res_idx));
            got++;
            res_idx++;
         end
      end
      chk("post_rst_count", got, 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
